mux_8to1: RTL and testbench
===========================

MUX_8TO1 -- requirements
Module: mux_8to1

Interface
REQ-001 Parameter RESET_VAL, default 1'b0, value loaded into y by reset.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port d  input  8  data lanes; d[i] is input i of the mux.
REQ-005 Port s  input  3  select, unsigned, 0..7.
REQ-006 Port y  output  1  registered selected bit.
REQ-007 Port y_valid  output  1  high when y holds a sampled d[s] rather than the reset value.

Function
REQ-008 The block SHALL have exactly one clock domain (clk) and no combinational path from d or s to y.
REQ-009 On each rising clk edge with rst low, y SHALL load d[s], for s = 0..7.
REQ-010 Latency from d/s change to y SHALL be exactly one clk cycle: y at edge N+1 reflects d and s sampled at edge N.
REQ-011 All 8 select codes SHALL be decoded; no select value SHALL yield X, hold, or a default other than d[s].
REQ-012 Selection SHALL depend only on d[s]; other lanes SHALL have no effect on y.
REQ-013 y_valid SHALL go high on the first rising edge with rst low after reset and stay high until the next reset.
REQ-014 Simultaneous change of d and s in one cycle SHALL produce y = new d[new s] on the next edge.
REQ-015 y SHALL change only on rising clk edges, never between them.

Reset
REQ-016 When rst is high at a rising clk edge, y SHALL become RESET_VAL and y_valid SHALL become 0, regardless of d and s.
REQ-017 Reset SHALL be synchronous only: asserting rst between edges SHALL not change y until the next rising edge.
REQ-018 Reset asserted mid-operation SHALL take priority over the mux update on that edge.
REQ-019 On the first edge with rst low, y SHALL load d[s] and y_valid SHALL rise in the same cycle.
REQ-020 Before the first reset edge, output values are don't-care for verification.

Verification
REQ-021 Select sweep: rst low, d=8'b10100000, s stepped 0..7 one per cycle -> y one cycle later = 0,0,0,0,0,1,0,1.
REQ-022 Walking one: for i=0..7, d=1<<i, s=i -> y=1 next cycle; same d with s=(i+1)%8 -> y=0.
REQ-023 Walking zero: d=~(1<<i), s=i -> y=0 next cycle; s≠i -> y=1.
REQ-024 Reset priority: d=8'hFF, s=3, rst high for 2 edges -> y=RESET_VAL, y_valid=0; rst low -> y=1, y_valid=1 after one edge.
REQ-025 Mid-edge reset pulse: rst high and low between two edges -> y and y_valid unaffected.
REQ-026 Random: 1000 cycles of random d, s -> y(N+1) == d(N)[s(N)] every cycle, checked against a reference model.

Source files
------------

// File: rtl/mux_8to1.sv
// Registered 8-to-1 single-bit multiplexer with synchronous reset.
// y carries d[s] one clock after sampling; y_valid marks that y is live data rather than RESET_VAL.
module mux_8to1 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    input  logic [2:0] s,
    output logic       y,
    output logic       y_valid
);

    logic sel_bit;

    // Every select code maps to its own lane, so no code can fall through to a default.
    always_comb begin
        sel_bit = d[0];
        case (s)
            3'd0: sel_bit = d[0];
            3'd1: sel_bit = d[1];
            3'd2: sel_bit = d[2];
            3'd3: sel_bit = d[3];
            3'd4: sel_bit = d[4];
            3'd5: sel_bit = d[5];
            3'd6: sel_bit = d[6];
            3'd7: sel_bit = d[7];
            default: sel_bit = d[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= RESET_VAL;
            y_valid <= 1'b0;
        end else begin
            y       <= sel_bit;
            y_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_8to1.sv
// Scoreboard bench for mux_8to1: each driven vector pushes its expected {y_valid, y}
// and the registered output is popped and compared one edge later.
module tb_mux_8to1;

    localparam logic RST_VAL = 1'b1;

    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic [2:0] s;
    logic       y;
    logic       y_valid;

    int vectors = 0;
    int errors  = 0;

    logic [1:0] exp_q[$];

    mux_8to1 #(.RESET_VAL(RST_VAL)) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .s       (s),
        .y       (y),
        .y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [1:0] actual, input logic [1:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got {valid,y}=%b expected %b", tag, actual, expected);
        end
    endtask

    // Drive one vector at the falling edge, predict the result, then compare after the next rising edge.
    task automatic applyStimulus(input string tag, input logic rv, input logic [7:0] dv, input logic [2:0] sv);
        logic [1:0] exp_val;
        @(negedge clk);
        rst = rv;
        d   = dv;
        s   = sv;
        exp_q.push_back(rv ? {1'b0, RST_VAL} : {1'b1, dv[sv]});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_scoreboard_empty"}, 2'b00, 2'b11);
        end else begin
            exp_val = exp_q.pop_front();
            checkOutput(tag, {y_valid, y}, exp_val);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] held;
        logic [7:0] sweep_d;
        logic [7:0] rd;
        logic [2:0] rs;

        rst = 1'b1;
        d   = 8'h00;
        s   = 3'd0;

        // Reset priority: all lanes high, reset held for two edges
        applyStimulus("reset_edge0", 1'b1, 8'hFF, 3'd3);
        applyStimulus("reset_edge1", 1'b1, 8'hFF, 3'd3);
        applyStimulus("reset_release", 1'b0, 8'hFF, 3'd3);

        // Select sweep over a sparse pattern
        sweep_d = 8'b1010_0000;
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("sweep_s%0d", i), 1'b0, sweep_d, 3'(i));
        end

        // Walking one and walking zero, on-lane and off-lane
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("walk1_on%0d", i), 1'b0, 8'(1 << i), 3'(i));
            applyStimulus($sformatf("walk1_off%0d", i), 1'b0, 8'(1 << i), 3'((i + 1) % 8));
            applyStimulus($sformatf("walk0_on%0d", i), 1'b0, ~8'(1 << i), 3'(i));
            applyStimulus($sformatf("walk0_off%0d", i), 1'b0, ~8'(1 << i), 3'((i + 3) % 8));
        end

        // Reset pulse entirely between two edges must not disturb the outputs
        applyStimulus("pre_pulse", 1'b0, 8'h55, 3'd2);
        held = {1'b1, 1'b1};
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkOutput("mid_pulse_hold", {y_valid, y}, held);
        applyStimulus("post_pulse", 1'b0, 8'h55, 3'd1);

        // Reset asserted mid-operation wins over the mux update
        applyStimulus("midop_reset", 1'b1, 8'hFF, 3'd7);
        applyStimulus("midop_release", 1'b0, 8'h00, 3'd7);

        // Random traffic with simultaneous d and s changes
        for (int n = 0; n < 1000; n++) begin
            rd = 8'($urandom);
            rs = 3'($urandom_range(0, 7));
            applyStimulus("random", 1'b0, rd, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
